alu_exec_stage: RTL and testbench

- Execute stage of the 12-bit CPU. Sits between the instruction decoder and writeback, and wraps the combinational ALU.
- Accepts one decoded instruction per valid/ready handshake and reads operands from an internal register file.
- Drives the ALU, then commits the result and the 5-bit flags {P,V,K,S,Z}.
- Applies predication using the P flag and presents the result on a valid/ready output.

---
 rtl/alu_exec_stage_if.sv | 45 ++++
 rtl/alu_exec_stage.sv | 141 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
// Handshake and ALU bus of the execute stage: decoded-instruction input,
// ALU operand/result channel and committed-result output.
interface alu_exec_stage_if #(
  parameter int RAW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic [3:0]      in_cond;
  logic [RAW-1:0]  in_rd;
  logic [RAW-1:0]  in_ra;
  logic [RAW-1:0]  in_rb;
  logic [11:0]     in_imm;
  logic            in_use_imm;
  logic            in_wr_en;
  logic            in_pred;
  logic [11:0]     alu_a;
  logic [11:0]     alu_b;
  logic [4:0]      alu_op;
  logic [3:0]      alu_cond;
  logic [4:0]      alu_flg_in;
  logic [11:0]     alu_q;
  logic [4:0]      alu_flg_out;
  logic            out_valid;
  logic            out_ready;
  logic [RAW-1:0]  out_rd;
  logic [11:0]     out_data;
  logic            out_wrote;
  logic            out_skipped;
  logic [4:0]      flags;

  modport master (
    output in_valid, in_op, in_cond, in_rd, in_ra, in_rb, in_imm, in_use_imm,
           in_wr_en, in_pred, alu_q, alu_flg_out, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, alu_cond, alu_flg_in,
           out_valid, out_rd, out_data, out_wrote, out_skipped, flags
  );

  modport slave (
    input  in_valid, in_op, in_cond, in_rd, in_ra, in_rb, in_imm, in_use_imm,
           in_wr_en, in_pred, alu_q, alu_flg_out, out_ready,
    output in_ready, alu_a, alu_b, alu_op, alu_cond, alu_flg_in,
           out_valid, out_rd, out_data, out_wrote, out_skipped, flags
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage of the 12-bit CPU: operand fetch from the register file,
// ALU drive, predicated commit of result and flags {P,V,K,S,Z}.
module alu_exec_stage #(
  parameter int NREGS = 16,
  parameter int RAW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [4:0]      op_q;
  logic [3:0]      cond_q;
  logic [RAW-1:0]  rd_q;
  logic            wr_en_q;
  logic            pred_q;
  logic [11:0]     a_q;
  logic [11:0]     b_q;
  logic [4:0]      flags_q;
  logic [11:0]     regs_q [NREGS];
  logic            in_ready_q;
  logic            out_valid_q;
  logic [RAW-1:0]  out_rd_q;
  logic [11:0]     out_data_q;
  logic            out_wrote_q;
  logic            out_skipped_q;

  logic [11:0]     rd_a_s;
  logic [11:0]     rd_b_s;
  logic            exec_s;
  logic            wr_s;

  // Operand fetch (R0 reads as zero) and commit qualification.
  always_comb begin
    rd_a_s = 12'h000;
    rd_b_s = 12'h000;
    if (bus.in_ra != {RAW{1'b0}}) begin
      rd_a_s = regs_q[bus.in_ra];
    end else begin
      rd_a_s = 12'h000;
    end
    if (bus.in_use_imm) begin
      rd_b_s = bus.in_imm;
    end else if (bus.in_rb != {RAW{1'b0}}) begin
      rd_b_s = regs_q[bus.in_rb];
    end else begin
      rd_b_s = 12'h000;
    end
    exec_s = !pred_q | flags_q[4];
    wr_s   = exec_s & wr_en_q & (rd_q != {RAW{1'b0}});
  end

  // Control FSM with register file, flags and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= 5'h00;
      cond_q        <= 4'h0;
      rd_q          <= {RAW{1'b0}};
      wr_en_q       <= 1'b0;
      pred_q        <= 1'b0;
      a_q           <= 12'h000;
      b_q           <= 12'h000;
      flags_q       <= 5'h00;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_rd_q      <= {RAW{1'b0}};
      out_data_q    <= 12'h000;
      out_wrote_q   <= 1'b0;
      out_skipped_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 12'h000;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.in_op;
            cond_q     <= bus.in_cond;
            rd_q       <= bus.in_rd;
            wr_en_q    <= bus.in_wr_en;
            pred_q     <= bus.in_pred;
            a_q        <= rd_a_s;
            b_q        <= rd_b_s;
            in_ready_q <= 1'b0;
            state_q    <= EXEC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        EXEC: begin
          if (exec_s) begin
            flags_q <= bus.alu_flg_out;
          end
          if (wr_s) begin
            regs_q[rd_q] <= bus.alu_q;
          end
          out_data_q    <= exec_s ? bus.alu_q : 12'h000;
          out_wrote_q   <= wr_s;
          out_skipped_q <= !exec_s;
          out_rd_q      <= rd_q;
          out_valid_q   <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_op      = op_q;
  assign bus.alu_cond    = cond_q;
  assign bus.alu_flg_in  = flags_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_wrote   = out_wrote_q;
  assign bus.out_skipped = out_skipped_q;
  assign bus.flags       = flags_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a small ALU model and a scoreboard
// of expected commits.
module tb_alu_exec_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_exec_stage_if #(.RAW(4)) bus ();

  alu_exec_stage #(.NREGS(16), .RAW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: 0x00 MOV, 0x04 ADD, 0x10 set P from condition (0: Z, 1: !Z, else 1).
  always_comb begin
    logic [12:0] sum;
    sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    bus.alu_q       = 12'h000;
    bus.alu_flg_out = bus.alu_flg_in;
    case (bus.alu_op)
      5'h00: begin
        bus.alu_q       = bus.alu_b;
        bus.alu_flg_out = {bus.alu_flg_in[4], 1'b0, 1'b0, bus.alu_b[11], bus.alu_b == 12'h000};
      end
      5'h04: begin
        bus.alu_q       = sum[11:0];
        bus.alu_flg_out = {bus.alu_flg_in[4],
                           (bus.alu_a[11] == bus.alu_b[11]) && (sum[11] != bus.alu_a[11]),
                           sum[12], sum[11], sum[11:0] == 12'h000};
      end
      5'h10: begin
        bus.alu_q = 12'h000;
        if (bus.alu_cond == 4'h0) begin
          bus.alu_flg_out = {bus.alu_flg_in[0], bus.alu_flg_in[3:0]};
        end else if (bus.alu_cond == 4'h1) begin
          bus.alu_flg_out = {!bus.alu_flg_in[0], bus.alu_flg_in[3:0]};
        end else begin
          bus.alu_flg_out = {1'b1, bus.alu_flg_in[3:0]};
        end
      end
      default: begin
        bus.alu_q       = 12'h000;
        bus.alu_flg_out = bus.alu_flg_in;
      end
    endcase
  end

  typedef struct {
    logic [3:0]  rd;
    logic [11:0] data;
    logic        wrote;
    logic        skipped;
    logic [4:0]  flags;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one instruction, wait for acceptance, push its expected commit.
  task automatic send(input logic [4:0] op, input logic [3:0] cond, input logic [3:0] rd,
                      input logic [3:0] ra, input logic [3:0] rb, input logic [11:0] imm,
                      input logic use_imm, input logic wr, input logic pred,
                      input logic [11:0] e_data, input logic e_wrote, input logic e_skip,
                      input logic [4:0] e_flags);
    int n;
    exp_t e;
    @(negedge clk);
    bus.in_op      = op;
    bus.in_cond    = cond;
    bus.in_rd      = rd;
    bus.in_ra      = ra;
    bus.in_rb      = rb;
    bus.in_imm     = imm;
    bus.in_use_imm = use_imm;
    bus.in_wr_en   = wr;
    bus.in_pred    = pred;
    bus.in_valid   = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk);
    e.rd = rd; e.data = e_data; e.wrote = e_wrote; e.skipped = e_skip; e.flags = e_flags;
    sb_q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    check("exec_out_valid", 32'(bus.out_valid), 32'd0);
    check("exec_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall, then consume.
  task automatic collect(input int hold);
    int n;
    exp_t e;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("out_latency", 32'(n), 32'd1);
    check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("out_rd", 32'(bus.out_rd), 32'(e.rd));
      check("out_data", 32'(bus.out_data), 32'(e.data));
      check("out_wrote", 32'(bus.out_wrote), 32'(e.wrote));
      check("out_skipped", 32'(bus.out_skipped), 32'(e.skipped));
      check("flags", 32'(bus.flags), 32'(e.flags));
      for (int i = 0; i < hold; i++) begin
        if (i == 1) begin
          bus.in_op = 5'h00; bus.in_rd = 4'hF; bus.in_imm = 12'h777;
          bus.in_use_imm = 1'b1; bus.in_wr_en = 1'b1; bus.in_pred = 1'b0;
          bus.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(bus.out_data), 32'(e.data));
        check("hold_rd", 32'(bus.out_rd), 32'(e.rd));
        check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = 5'h00; bus.in_cond = 4'h0; bus.in_rd = 4'h0;
    bus.in_ra = 4'h0; bus.in_rb = 4'h0; bus.in_imm = 12'h000; bus.in_use_imm = 1'b0;
    bus.in_wr_en = 1'b0; bus.in_pred = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_rd", 32'(bus.out_rd), 32'd0);
    check("rst_out_wrote", 32'(bus.out_wrote), 32'd0);
    check("rst_out_skipped", 32'(bus.out_skipped), 32'd0);

    // op cond rd ra rb imm use_imm wr pred | data wrote skip flags
    send(5'h00, 4'h0, 4'd1, 4'd0, 4'd0, 12'h123, 1'b1, 1'b1, 1'b0, 12'h123, 1'b1, 1'b0, 5'b00000);
    collect(0);
    send(5'h04, 4'h0, 4'd2, 4'd1, 4'd0, 12'hEDD, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 5'b00101);
    collect(0);
    send(5'h04, 4'h0, 4'd5, 4'd2, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 5'b00001);
    collect(0);
    // P=0: predicated ADD is squashed and leaves reg3 at zero
    send(5'h04, 4'h0, 4'd3, 4'd1, 4'd0, 12'h002, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 5'b00001);
    collect(0);
    send(5'h04, 4'h0, 4'd9, 4'd3, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 5'b00001);
    collect(0);
    send(5'h10, 4'h0, 4'd0, 4'd0, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 5'b10001);
    collect(0);
    send(5'h04, 4'h0, 4'd3, 4'd1, 4'd0, 12'h001, 1'b1, 1'b1, 1'b1, 12'h124, 1'b1, 1'b0, 5'b10000);
    collect(0);
    send(5'h00, 4'h0, 4'd6, 4'd0, 4'd0, 12'h055, 1'b1, 1'b1, 1'b0, 12'h055, 1'b1, 1'b0, 5'b10000);
    collect(5);
    send(5'h00, 4'h0, 4'd0, 4'd0, 4'd0, 12'hFFF, 1'b1, 1'b1, 1'b0, 12'hFFF, 1'b0, 1'b0, 5'b10010);
    collect(0);
    send(5'h04, 4'h0, 4'd7, 4'd0, 4'd0, 12'h001, 1'b1, 1'b1, 1'b0, 12'h001, 1'b1, 1'b0, 5'b10000);
    collect(0);
    send(5'h04, 4'h0, 4'd11, 4'd3, 4'd7, 12'h000, 1'b0, 1'b1, 1'b0, 12'h125, 1'b1, 1'b0, 5'b10000);
    collect(0);

    // Reset while the MOV to R4 is in EXEC: nothing may commit.
    send(5'h00, 4'h0, 4'd4, 4'd0, 4'd0, 12'hABC, 1'b1, 1'b1, 1'b0, 12'hABC, 1'b1, 1'b0, 5'b10000);
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_flags", 32'(bus.flags), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    send(5'h04, 4'h0, 4'd10, 4'd4, 4'd0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 5'b00001);
    collect(0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
